// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: opcode values and FSM states.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_GE   = 4'h2;
    localparam logic [3:0] OP_LT   = 4'h3;
    localparam logic [3:0] OP_NE   = 4'h4;
    localparam logic [3:0] OP_EQ   = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_ROL  = 4'h9;
    localparam logic [3:0] OP_ROR  = 4'hA;
    localparam logic [3:0] OP_SLL  = 4'hB;
    localparam logic [3:0] OP_SRL  = 4'hC;
    localparam logic [3:0] OP_LAST = 4'hC;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_LAST;
    endfunction

endpackage

// File: rtl/alu_cmd_driver_if.sv
// Command, ALU and response signals of alu_cmd_driver.
// master = the driver itself; slave = sequencer, ALU and response consumer.
interface alu_cmd_driver_if #(
    parameter int unsigned W = 32
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [3:0]   cmd_op;

    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_cnt;
    logic [W-1:0] alu_d;
    logic         alu_carry;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_d;
    logic         rsp_carry;
    logic [3:0]   rsp_op;
    logic         rsp_err;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_d, alu_carry, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_cnt,
               rsp_valid, rsp_d, rsp_carry, rsp_op, rsp_err
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_op, alu_d, alu_carry, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_cnt,
               rsp_valid, rsp_d, rsp_carry, rsp_op, rsp_err
    );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with registered ready (= not full after this edge).
module alu_cmd_fifo #(
    parameter int unsigned WIDTH = 68,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             ready,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ready_q, ready_d;
    logic             do_push, do_pop;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign do_push = push && ready_q;
    assign do_pop  = pop && !empty;
    assign empty   = (count_q == '0);
    assign ready   = ready_q;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        ready_d  = (count_d != (AW+1)'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator for a combinational 32-bit ALU: queues commands, issues them, returns results.
// Optional feature macro: ALU_DRV_STATS_EN adds stat_ops/stat_err saturating counters.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int unsigned W       = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_cmd_driver_if.master     bus
`ifdef ALU_DRV_STATS_EN
    ,
    output logic [15:0]          stat_ops,
    output logic [15:0]          stat_err
`endif
);
    localparam int unsigned FW = 2 * W + 4;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]     alu_cnt_q, alu_cnt_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [W-1:0]   rsp_d_q, rsp_d_d;
    logic           rsp_carry_q, rsp_carry_d;
    logic [3:0]     rsp_op_q, rsp_op_d;
    logic           rsp_err_q, rsp_err_d;

    logic           fifo_ready, fifo_empty, fifo_push, start;
    logic [FW-1:0]  fifo_rdata;
    logic [W-1:0]   head_a, head_b;
    logic [3:0]     head_op;
    logic           head_legal;

    assign fifo_push = bus.cmd_valid && fifo_ready;

    alu_cmd_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata ({bus.cmd_a, bus.cmd_b, bus.cmd_op}),
        .ready (fifo_ready),
        .pop   (start),
        .rdata (fifo_rdata),
        .empty (fifo_empty)
    );

    assign head_a     = fifo_rdata[FW-1 -: W];
    assign head_b     = fifo_rdata[W+3 -: W];
    assign head_op    = fifo_rdata[3:0];
    assign head_legal = op_legal(head_op);

    // A new op starts from IDLE, or from RESP on the same edge as its handshake (no bubble).
    assign start = !fifo_empty &&
                   ((state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = head_legal ? ISSUE : RESP;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = start ? (head_legal ? ISSUE : RESP) : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_cnt_d   = alu_cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_d_d     = rsp_d_q;
        rsp_carry_d = rsp_carry_q;
        rsp_op_d    = rsp_op_q;
        rsp_err_d   = rsp_err_q;

        if (start && head_legal) begin
            alu_a_d   = head_a;
            alu_b_d   = head_b;
            alu_cnt_d = head_op;
        end

        // Illegal ops bypass the ALU entirely and leave its operand registers untouched.
        if (start && !head_legal) begin
            rsp_valid_d = 1'b1;
            rsp_d_d     = '0;
            rsp_carry_d = 1'b0;
            rsp_op_d    = head_op;
            rsp_err_d   = 1'b1;
        end else if ((state_q == RESP) && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            ISSUE: cnt_d = 4'(ALU_LAT - 1);
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_d_d     = bus.alu_d;
                    rsp_carry_d = (alu_cnt_q == OP_ADD) && bus.alu_carry;
                    rsp_op_d    = alu_cnt_q;
                    rsp_err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_d_q     <= '0;
            rsp_carry_q <= 1'b0;
            rsp_op_q    <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cnt_q   <= alu_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_d_q     <= rsp_d_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_op_q    <= rsp_op_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.cmd_ready = fifo_ready;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_cnt   = alu_cnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_d     = rsp_d_q;
    assign bus.rsp_carry = rsp_carry_q;
    assign bus.rsp_op    = rsp_op_q;
    assign bus.rsp_err   = rsp_err_q;

`ifdef ALU_DRV_STATS_EN
    logic        rsp_hs;
    logic [15:0] stat_ops_q, stat_ops_d, stat_err_q, stat_err_d;

    assign rsp_hs = rsp_valid_q && bus.rsp_ready;

    always_comb begin
        stat_ops_d = stat_ops_q;
        stat_err_d = stat_err_q;
        if (rsp_hs && (stat_ops_q != '1)) stat_ops_d = stat_ops_q + 16'd1;
        if (rsp_hs && rsp_err_q && (stat_err_q != '1)) stat_err_d = stat_err_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops_q <= '0;
            stat_err_q <= '0;
        end else begin
            stat_ops_q <= stat_ops_d;
            stat_err_q <= stat_err_d;
        end
    end

    assign stat_ops = stat_ops_q;
    assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Scoreboard bench for alu_cmd_driver (DEPTH=4, ALU_LAT=1) with a behavioural ALU.
module tb_alu_cmd_driver;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] d;
        logic        c;
        logic [3:0]  op;
        logic        err;
    } rsp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_cmd_driver_if #(.W(32)) bus ();

`ifdef ALU_DRV_STATS_EN
    logic [15:0] stat_ops, stat_err;
`endif

    alu_cmd_driver #(.W(32), .DEPTH(4), .ALU_LAT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ALU_DRV_STATS_EN
        ,
        .stat_ops (stat_ops),
        .stat_err (stat_err)
`endif
    );

    // Reference ALU: {carry, result}; carry of SUB is the borrow, other ops return noise.
    function automatic logic [32:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        int s;
        s = int'(b[4:0]);
        case (op)
            4'h0: return {1'b0, a} + {1'b0, b};
            4'h1: return {1'b0, a} - {1'b0, b};
            4'h2: return {^a, 31'd0, a >= b};
            4'h3: return {^a, 31'd0, a < b};
            4'h4: return {^a, 31'd0, a != b};
            4'h5: return {^a, 31'd0, a == b};
            4'h6: return {^a, a & b};
            4'h7: return {^a, a | b};
            4'h8: return {^a, a ^ b};
            4'h9: return {^a, (a << s) | (a >> (32 - s))};
            4'hA: return {^a, (a >> s) | (a << (32 - s))};
            4'hB: return {^a, a << s};
            4'hC: return {^a, a >> s};
            default: return {1'b1, 32'hDEAD_BEEF};
        endcase
    endfunction

    function automatic rsp_t expect_rsp(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        logic [32:0] m;
        if (op > 4'hC) return '{d: 32'd0, c: 1'b0, op: op, err: 1'b1};
        m = alu_model(op, a, b);
        return '{d: m[31:0], c: (op == 4'h0) ? m[32] : 1'b0, op: op, err: 1'b0};
    endfunction

    always_comb {bus.alu_carry, bus.alu_d} = alu_model(bus.alu_cnt, bus.alu_a, bus.alu_b);

    rsp_t        sb[$];
    int unsigned hs_cyc[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    int unsigned acc_cyc = 0;
    int unsigned last_rise = 0;
    int unsigned n_rsp = 0;
    logic        ready_ctl = 1'b1;
    logic        rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        bus.rsp_ready = rand_rdy ? 1'($urandom_range(0, 1)) : ready_ctl;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Accept monitor: an accepted command immediately contributes its expected response.
    always @(negedge clk) begin
        if (rst_n && bus.cmd_valid && bus.cmd_ready) begin
            sb.push_back(expect_rsp(bus.cmd_op, bus.cmd_a, bus.cmd_b));
            acc_cyc = cyc;
        end
    end

    logic prev_valid = 1'b0;
    logic stall_hold = 1'b0;
    rsp_t held;

    always @(negedge clk) begin
        rsp_t act, exp;
        act = {bus.rsp_d, bus.rsp_carry, bus.rsp_op, bus.rsp_err};
        if (!rst_n) begin
            prev_valid = 1'b0;
            stall_hold = 1'b0;
        end else begin
            if (bus.rsp_valid && !prev_valid) last_rise = cyc;
            if (stall_hold) begin
                checks++;
                if (!bus.rsp_valid || act !== held) begin
                    failures++;
                    $display("FAIL rsp_stable actual=%0h required=%0h", act, held);
                end
            end
            stall_hold = bus.rsp_valid && !bus.rsp_ready;
            held = act;
            if (bus.rsp_valid && bus.rsp_ready) begin
                hs_cyc.push_back(cyc);
                n_rsp++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_rsp actual=%0h required=none", act);
                end else begin
                    exp = sb.pop_front();
                    if (act !== exp) begin
                        failures++;
                        $display("FAIL rsp_data actual=%0h required=%0h", act, exp);
                    end
                end
            end
            prev_valid = bus.rsp_valid;
        end
    end

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int unsigned maxw, output bit ok);
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_valid = 1'b1;
        ok = 1'b0;
        for (int unsigned i = 0; i < maxw; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic send_ok(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        send(op, a, b, 40, ok);
        chk("send_accept", 64'(ok), 64'd1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int unsigned i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.rsp_valid) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain", 64'(done), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({bus.cmd_ready, bus.rsp_valid, bus.rsp_carry, bus.rsp_err,
                                 bus.rsp_op, bus.alu_cnt}), 64'd0);
        chk({tag, "_rsp_d"}, 64'(bus.rsp_d), 64'd0);
        chk({tag, "_alu_ab"}, {bus.alu_a, bus.alu_b}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.cmd_op = '0;
        #1 rst_n = 1'b0;
        #2 check_all_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_reset", 64'(bus.cmd_ready), 64'd1);

        // Latency: accept edge to rsp_valid rise is ALU_LAT+2 edges.
        send_ok(4'h0, 32'hFFFF_FFFF, 32'd1);
        drain();
        chk("latency", 64'(last_rise - (acc_cyc + 1)), 64'd3);
        chk("add_carry", 64'({bus.rsp_d, bus.rsp_carry}), 64'd1);

        send_ok(4'h1, 32'd5, 32'd7);
        drain();
        chk("sub_carry_masked", 64'({bus.rsp_d, bus.rsp_carry}), {31'd0, 32'hFFFF_FFFE, 1'b0});
        send_ok(4'hC, 32'h8000_0000, 32'h24);
        drain();
        chk("srl_d", 64'(bus.rsp_d), 64'h0800_0000);

        // Back-pressure: one in flight plus four queued.
        ready_ctl = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        hs_cyc.delete();
        n = 0;
        for (int i = 0; i < 6; i++) begin
            send(4'($urandom_range(0, 12)), $urandom, $urandom, 8, ok);
            if (ok) n++;
        end
        chk("bp_accepted", 64'(n), 64'd5);
        chk("bp_cmd_ready_low", 64'(bus.cmd_ready), 64'd0);
        ready_ctl = 1'b1;
        drain();
        chk("bp_rsp_count", 64'(hs_cyc.size()), 64'd5);
        for (int i = 1; i < hs_cyc.size(); i++)
            chk("bp_spacing", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd3);

        // Illegal op leaves the ALU registers at the previous op.
        send_ok(4'h8, $urandom, $urandom);
        send_ok(4'hE, $urandom, $urandom);
        drain();
        chk("illegal_alu_cnt", 64'(bus.alu_cnt), 64'h8);
        chk("illegal_err", 64'({bus.rsp_err, bus.rsp_d}), {31'd0, 1'b1, 32'd0});
        send_ok(4'h6, $urandom, $urandom);
        drain();
        chk("legal_after_illegal", 64'(bus.rsp_err), 64'd0);

        // Reset during WAIT with two commands queued.
        send_ok(4'h0, 32'd1, 32'd2);
        send_ok(4'h0, 32'd3, 32'd4);
        send_ok(4'h0, 32'd5, 32'd6);
        rst_n = 1'b0;
        sb.delete();
        #1 check_all_zero("reset_mid");
        @(negedge clk) rst_n = 1'b1;
        n = int'(n_rsp);
        repeat (12) @(posedge clk);
        #1;
        chk("no_rsp_after_reset", 64'(int'(n_rsp) - n), 64'd0);
        chk("ready_after_mid_reset", 64'({bus.cmd_ready, bus.rsp_valid}), 64'b10);

`ifdef ALU_DRV_STATS_EN
        send_ok(4'h0, $urandom, $urandom);
        send_ok(4'h1, $urandom, $urandom);
        send_ok(4'h7, $urandom, $urandom);
        send_ok(4'hF, $urandom, $urandom);
        drain();
        @(posedge clk);
        #1;
        chk("stat_ops", 64'(stat_ops), 64'd4);
        chk("stat_err", 64'(stat_err), 64'd1);
`endif

        // Random traffic with random response back-pressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            b = $urandom;
            send_ok(4'($urandom_range(0, 15)), a, b);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rand_rdy = 1'b0;
        ready_ctl = 1'b1;
        drain();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
